// File: rtl/rob_slot_scheduler_if.sv
// Handshake bundle between decode/execute and the ROB slot scheduler.
// The scheduler connects through the slave modport.
interface rob_slot_scheduler_if #(
    parameter int IDX_W = 4
) ();
    logic             in_allocate;
    logic [IDX_W-1:0] out_alloc_idx;
    logic             out_alloc_ready;
    logic             out_stall;
    logic             in_complete;
    logic [IDX_W-1:0] in_complete_idx;
    logic             in_complete_exc;
    logic             in_flush_req;
    logic             out_commit;
    logic [IDX_W-1:0] out_commit_idx;
    logic             out_exception;
    logic [IDX_W-1:0] out_exception_idx;
    logic             out_flush;
    logic [IDX_W:0]   out_count;

    modport master (
        output in_allocate, in_complete, in_complete_idx,
        output in_complete_exc, in_flush_req,
        input  out_alloc_idx, out_alloc_ready, out_stall,
        input  out_commit, out_commit_idx, out_exception,
        input  out_exception_idx, out_flush, out_count
    );

    modport slave (
        input  in_allocate, in_complete, in_complete_idx,
        input  in_complete_exc, in_flush_req,
        output out_alloc_idx, out_alloc_ready, out_stall,
        output out_commit, out_commit_idx, out_exception,
        output out_exception_idx, out_flush, out_count
    );
endinterface

// File: rtl/rob_slot_scheduler.sv
// Reorder-buffer slot allocation, completion tracking, in-order retire
// and a two-cycle FLUSH/RECOVER sequence that clears every slot.
module rob_slot_scheduler #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input logic               clk,
    input logic               reset,
    rob_slot_scheduler_if.slave rob
);
    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ENTRIES);

    state_t             state;
    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic [IDX_W:0]     count;
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] done;
    logic [ENTRIES-1:0] exc;

    logic           run;
    logic           alloc_ready;
    logic           alloc_fire;
    logic           head_done;
    logic           commit;
    logic           exception;
    logic           complete_ok;
    logic [IDX_W:0] count_next;

    assign run         = (state == RUN);
    // A flush request pre-empts allocation in the same cycle
    assign alloc_ready = run && (count != FULL) && !rob.in_flush_req;
    assign alloc_fire  = rob.in_allocate && alloc_ready;
    assign head_done   = run && valid[head] && done[head];
    assign commit      = head_done && !exc[head];
    assign exception   = head_done && exc[head];
    assign complete_ok = rob.in_complete && valid[rob.in_complete_idx];

    assign count_next = count
                      + {{IDX_W{1'b0}}, alloc_fire}
                      - {{IDX_W{1'b0}}, commit};

    assign rob.out_alloc_idx     = tail;
    assign rob.out_alloc_ready   = alloc_ready;
    assign rob.out_stall         = rob.in_allocate && !alloc_ready;
    assign rob.out_commit        = commit;
    assign rob.out_commit_idx    = head;
    assign rob.out_exception     = exception;
    assign rob.out_exception_idx = head;
    assign rob.out_flush         = (state == FLUSH);
    assign rob.out_count         = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            exc   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (complete_ok) begin
                        done[rob.in_complete_idx] <= 1'b1;
                        exc[rob.in_complete_idx]  <= rob.in_complete_exc;
                    end
                    if (alloc_fire) begin
                        valid[tail] <= 1'b1;
                        done[tail]  <= 1'b0;
                        exc[tail]   <= 1'b0;
                        tail        <= tail + 1'b1;
                    end
                    if (commit) begin
                        valid[head] <= 1'b0;
                        head        <= head + 1'b1;
                    end
                    count <= count_next;
                    if (rob.in_flush_req || exception) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                    valid <= '0;
                    done  <= '0;
                    exc   <= '0;
                    state <= RECOVER;
                end
                RECOVER: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: doc/rob_slot_scheduler.md
Name: rob_slot_scheduler

Overview:
- Controls allocation, completion tracking and in-order retirement of reorder-buffer slots.
- Decode requests a slot per instruction that writes back; the block returns the tail index or a stall.
- Execute/memory report completion by index. The head entry retires in order, one per cycle.
- An exception at the head, or an external branch flush request, triggers a sequenced flush that clears every slot.

Parameters:
ENTRIES, 16, number of ROB slots (power of two)
IDX_W, 4, index width = log2(ENTRIES)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_allocate  input  1  decode requests a slot this cycle
out_alloc_idx  output  IDX_W  slot granted (current tail)
out_alloc_ready  output  1  a slot can be granted this cycle
out_stall  output  1  in_allocate & ~out_alloc_ready; freezes PC and IF/ID
in_complete  input  1  completion strobe
in_complete_idx  input  IDX_W  slot being completed
in_complete_exc  input  1  completing instruction raised an exception
in_flush_req  input  1  branch-taken flush request (single-cycle pulse)
out_commit  output  1  head slot retires this cycle
out_commit_idx  output  IDX_W  index of the retiring slot
out_exception  output  1  head slot holds an exception (1-cycle pulse)
out_exception_idx  output  IDX_W  index of the excepting slot
out_flush  output  1  pipeline/ROB flush pulse
out_count  output  IDX_W+1  occupied slots, 0..ENTRIES

Behaviour:
- State per slot: valid, done, exc bits. Pointers: head, tail (IDX_W bits, wrap modulo ENTRIES). Counter: count (IDX_W+1 bits).
- Reset (reset=0, asynchronous):
  - head=tail=count=0; all valid/done/exc=0; FSM=RUN.
  - Outputs: out_alloc_ready=1, out_alloc_idx=0, all strobes and out_flush=0, out_count=0.
- FSM has three states: RUN, FLUSH, RECOVER.
- RUN:
  - out_alloc_ready = (count != ENTRIES).
  - On in_allocate & ready: set valid[tail]=1, done=0, exc=0; tail++ (wraps 15->0).
  - out_alloc_idx always shows the current tail, combinationally.
- Completion:
  - If in_complete & valid[in_complete_idx]: set done=1 and exc=in_complete_exc.
  - Completion to an invalid slot is ignored.
  - In FLUSH and RECOVER, completion is ignored.
- Commit (combinational on registered state, RUN only):
  - If valid[head] & done[head] & ~exc[head]: out_commit=1 and out_commit_idx=head. On the clock edge, valid[head]=0 and head++.
  - At most one commit per cycle.
- Exception:
  - If valid[head] & done[head] & exc[head]: out_exception=1, out_exception_idx=head, no commit, next state FLUSH.
- count update:
  - count_next = count + alloc_fire - commit_fire.
  - Simultaneous allocate and commit leaves count unchanged.
  - When full (count=16), allocation is refused even if a commit occurs the same cycle; ready uses the registered count.
- in_flush_req in RUN:
  - Next state FLUSH.
  - An allocation in the same cycle is suppressed (ready forced 0 when in_flush_req=1).
  - A commit in the same cycle still happens.
  - in_flush_req has priority over an exception in the same cycle; out_exception still pulses.
- FLUSH (exactly 1 cycle):
  - out_flush=1, out_alloc_ready=0.
  - On exit: clear all valid/done/exc; head=tail=count=0; next state RECOVER.
- RECOVER (exactly 1 cycle):
  - out_alloc_ready=0, out_flush=0; next state RUN.
  - Lets the refetched instruction reach decode.
- in_flush_req while in FLUSH or RECOVER is ignored.
- Reset asserted mid-flush returns immediately to the reset values.
- out_stall is high whenever in_allocate=1 and ready=0, including during FLUSH and RECOVER.

Test Plan:
- Reset, then allocate 3 consecutive cycles -> out_alloc_idx 0,1,2; out_count=3; no commit until completion.
- Complete idx 1, then idx 0 -> no commit after idx 1; after idx 0, commits of 0 then 1 on consecutive cycles (out_commit_idx 0,1); out_count=1.
- Allocate 16 with no completions -> out_count=16, out_alloc_ready=0. Assert in_allocate -> out_stall=1. Complete idx 0 -> commit 0, then allocation resumes at idx 0 (wrap).
- Complete head idx 0 with in_complete_exc=1 -> out_exception=1 with idx 0 for one cycle; out_flush=1 next cycle; then one RECOVER cycle with ready=0; then RUN with out_count=0 and out_alloc_idx=0.
- in_flush_req pulse together with in_allocate=1 at count=5 -> allocation dropped (out_stall=1), out_flush next cycle, out_count=0 two cycles later.
- Drive reset=0 during FLUSH -> all outputs return to reset values asynchronously; FSM is RUN after reset releases.
